deserializador: RTL and testbench
=================================

// Module: deserializador
// PURPOSE
//  Serial-to-parallel receiver: the far end of the universal shift register's serial output.
//  It captures a framed stream of WIDTH bits on S_IN.
//  It assembles them MSB-first or LSB-first and presents the word on Q with a VALID/ACK handshake.
//  Sits downstream of a PUSH-mode shift register (its S_OUT drives our S_IN); ENB paces both.
// PARAMETERS
//  WIDTH  4  word width in bits (>=2); counter width CW = $clog2(WIDTH+1)
// PORTS
//  CLK      in   1      clock, all state on rising edge
//  RST_N    in   1      synchronous active-low reset
//  ENB      in   1      bit-enable; S_IN is sampled only on edges with ENB=1
//  START    in   1      frame start strobe, honoured only when ENB=1
//  DIR      in   1      0 = MSB first (shift left), 1 = LSB first (shift right); latched at START
//  S_IN     in   1      serial data
//  ACK      in   1      consumer accepts Q
//  Q        out  WIDTH  last completed word
//  VALID    out  1      Q holds an unacknowledged word
//  BUSY     out  1      frame in progress
//  OVERRUN  out  1      sticky: a completed word was dropped
// BEHAVIOUR
//  Reset (RST_N=0 at edge): state=IDLE, Q=0, VALID=0, BUSY=0, OVERRUN=0, count=0, shreg=0; wins over all.
//  FSM IDLE:
//   - Edge with START&ENB samples S_IN as bit 0, sets count=1, latches DIR, goes RECV, BUSY=1.
//   - START with ENB=0 is ignored.
//  FSM RECV:
//   - Each edge with ENB=1 samples S_IN and increments count.
//   - ENB=0 stalls: shreg and count hold, BUSY stays 1.
//  Shift rule:
//   - DIR=0: shreg <= {shreg[WIDTH-2:0], S_IN}.
//   - DIR=1: shreg <= {S_IN, shreg[WIDTH-1:1]}.
//  Completion: the edge sampling bit WIDTH-1 transfers the assembled word (incl. that bit) to Q.
//   - Same edge: VALID=1, state=IDLE, BUSY=0.
//   - Latency: Q/VALID visible the cycle after the last bit edge.
//   - Back-to-back: START may be asserted the very next cycle; no dead cycle.
//  START&ENB during RECV: restart. Partial word discarded, this edge samples new bit 0, count=1, DIR relatched.
//  Handshake: VALID clears on the edge where VALID&ACK. ACK with VALID=0 has no effect.
//  Completion while VALID=1:
//   - If ACK=1 on that edge: new word loaded, VALID stays 1, no overrun.
//   - If ACK=0 on that edge: Q keeps the old word, new word dropped, OVERRUN<=1.
//  OVERRUN clears only on reset.
//  Q changes only on a completion accepted per the rules above; it is stable otherwise.
// STRUCTURE
//  definitions.v (shared defines file):
//   - add `RX_IDLE 1'b0, `RX_RECV 1'b1 next to `LOAD/`PUSH/`CYCLE.
//   - add `MSB_FIRST 1'b0, `LSB_FIRST 1'b1.
//  Sub-module contador_bits #(CW):
//   - synchronous counter with CLR, INC and TC (terminal count = WIDTH-1) output.
//   - instantiated once.
//  Top level holds FSM, shreg, Q, and VALID/OVERRUN logic.
// TESTING
//  1 Reset: RST_N=0 for 2 edges with START=1,S_IN=1 -> Q=0, VALID=0, BUSY=0, OVERRUN=0.
//  2 Loopback: registro LOAD 4'hD then PUSH DIR=0 feeding S_IN, START on 1st PUSH edge, DIR=0
//    -> bits 1,1,0,1 -> Q=4'hD, VALID=1 one cycle after 4th edge; ACK -> VALID=0 next edge.
//  3 LSB first: DIR=1, bits 0,1,0,1 -> Q=4'hA; DIR toggled mid-frame has no effect.
//  4 Stall: 2 bits, ENB=0 for 3 cycles (S_IN toggling), 2 bits -> same word as unstalled, BUSY=1 throughout.
//  5 Overrun: frames 4'h3 then 4'hC, no ACK -> Q=4'h3, OVERRUN=1.
//    Repeat after reset with ACK on 2nd completion edge -> Q=4'hC, VALID=1, OVERRUN=0.
//  6 Restart/reset mid-frame:
//    - START after 2 bits then 1,0,0,1 -> Q=4'h9.
//    - RST_N=0 after 2 bits -> BUSY=0, Q=0, next frame received correctly.

Source files
------------

// File: rtl/deserializador_pkg.sv
// Shared definitions for the serial-to-parallel receiver.
package deserializador_pkg;

  // Receiver FSM states.
  typedef enum logic {
    RxIdle = 1'b0,
    RxRecv = 1'b1
  } rx_state_e;

  // Bit-order selection, latched at frame start.
  localparam logic MsbFirst = 1'b0;
  localparam logic LsbFirst = 1'b1;

endpackage

// File: rtl/deserializador_contador_bits.sv
// Bit counter for the receiver: clear, increment and terminal-count flag.
// CLR together with INC loads 1 so a frame start counts its own first bit.
module deserializador_contador_bits #(
  parameter int unsigned CW   = 3,
  parameter int unsigned TERM = 3
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic CLR,
  input  logic INC,
  output logic TC
);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count.
  always_comb begin
    cnt_d = cnt_q;
    if (CLR) begin
      cnt_d = INC ? CW'(1) : '0;
    end else if (INC) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Terminal count: the next sampled bit is the last of the word.
  assign TC = (cnt_q == CW'(TERM));

endmodule

// File: rtl/deserializador.sv
// Serial-to-parallel receiver with VALID/ACK handshake and sticky overrun flag.
module deserializador
  import deserializador_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             ENB,
  input  logic             START,
  input  logic             DIR,
  input  logic             S_IN,
  input  logic             ACK,
  output logic [WIDTH-1:0] Q,
  output logic             VALID,
  output logic             BUSY,
  output logic             OVERRUN
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  rx_state_e        state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             dir_q, dir_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;

  logic             cnt_clr, cnt_inc, cnt_tc;
  logic             word_done;
  logic             frame_start;
  logic [WIDTH-1:0] shift_base;
  logic             shift_dir;
  logic [WIDTH-1:0] shifted;

  deserializador_contador_bits #(
    .CW   (CW),
    .TERM (WIDTH - 1)
  ) u_contador_bits (
    .CLK   (CLK),
    .RST_N (RST_N),
    .CLR   (cnt_clr),
    .INC   (cnt_inc),
    .TC    (cnt_tc)
  );

  assign frame_start = ENB & START;

  // Shift datapath; a frame start shifts into an empty word with the new direction.
  always_comb begin
    shift_base = frame_start ? '0 : shreg_q;
    shift_dir  = frame_start ? DIR : dir_q;
    if (shift_dir == LsbFirst) begin
      shifted = {S_IN, shift_base[WIDTH-1:1]};
    end else begin
      shifted = {shift_base[WIDTH-2:0], S_IN};
    end
  end

  // FSM next state, shift register and counter control.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    dir_d     = dir_q;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    word_done = 1'b0;
    unique case (state_q)
      RxIdle: begin
        if (frame_start) begin
          shreg_d = shifted;
          dir_d   = DIR;
          cnt_clr = 1'b1;
          cnt_inc = 1'b1;
          state_d = RxRecv;
        end
      end
      RxRecv: begin
        if (frame_start) begin
          // Restart: discard the partial word.
          shreg_d = shifted;
          dir_d   = DIR;
          cnt_clr = 1'b1;
          cnt_inc = 1'b1;
        end else if (ENB) begin
          shreg_d = shifted;
          if (cnt_tc) begin
            word_done = 1'b1;
            cnt_clr   = 1'b1;
            state_d   = RxIdle;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      default: state_d = RxIdle;
    endcase
  end

  // Output word, handshake and overrun tracking.
  always_comb begin
    q_d       = q_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (valid_q && ACK) begin
      valid_d = 1'b0;
    end
    if (word_done) begin
      if (!valid_q || ACK) begin
        q_d     = shifted;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= RxIdle;
      shreg_q   <= '0;
      q_q       <= '0;
      dir_q     <= MsbFirst;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      q_q       <= q_d;
      dir_q     <= dir_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign Q       = q_q;
  assign VALID   = valid_q;
  assign BUSY    = (state_q == RxRecv);
  assign OVERRUN = overrun_q;

endmodule

// File: tb/tb_deserializador.sv
// Directed bench for deserializador: per-cycle vector table plus a loopback sequence.
module tb_deserializador;

  localparam int unsigned WIDTH = 4;

  logic             CLK = 1'b0;
  logic             RST_N, ENB, START, DIR, S_IN, ACK;
  logic [WIDTH-1:0] Q;
  logic             VALID, BUSY, OVERRUN;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  deserializador #(
    .WIDTH (WIDTH)
  ) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .ENB     (ENB),
    .START   (START),
    .DIR     (DIR),
    .S_IN    (S_IN),
    .ACK     (ACK),
    .Q       (Q),
    .VALID   (VALID),
    .BUSY    (BUSY),
    .OVERRUN (OVERRUN)
  );

  // One clock of stimulus and the outputs expected just after that edge.
  typedef struct {
    logic             rst_n, enb, start, dir, s_in, ack;
    logic [WIDTH-1:0] q;
    logic             valid, busy, overrun;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, e, s, d, i, a,
                     input logic [WIDTH-1:0] q, input logic v, b, o);
    vec_t t;
    t.rst_n = r; t.enb = e; t.start = s; t.dir = d; t.s_in = i; t.ack = a;
    t.q = q; t.valid = v; t.busy = b; t.overrun = o;
    vq.push_back(t);
  endtask

  task automatic drive(input logic r, e, s, d, i, a);
    RST_N = r; ENB = e; START = s; DIR = d; S_IN = i; ACK = a;
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [WIDTH-1:0] q,
                       input logic v, b, o);
    n_tests++;
    if ({Q, VALID, BUSY, OVERRUN} !== {q, v, b, o}) begin
      n_fail++;
      $display("FAIL %s: got Q=%h V=%b B=%b O=%b, want Q=%h V=%b B=%b O=%b",
               name, Q, VALID, BUSY, OVERRUN, q, v, b, o);
    end
  endtask

  logic [WIDTH-1:0] sr;

  initial begin
    RST_N = 1'b0; ENB = 1'b0; START = 1'b0; DIR = 1'b0; S_IN = 1'b0; ACK = 1'b0;
    #1;

    //   r  e  s  d  i  a    Q     V  B  O
    // Reset held two edges with START and S_IN high.
    add(0, 1, 1, 0, 1, 0, 4'h0, 0, 0, 0);
    add(0, 1, 1, 0, 1, 0, 4'h0, 0, 0, 0);
    // LSB first 0,1,0,1 -> A; DIR toggled mid-frame ignored.
    add(1, 1, 1, 1, 0, 0, 4'h0, 0, 1, 0);
    add(1, 1, 0, 0, 1, 0, 4'h0, 0, 1, 0);
    add(1, 1, 0, 0, 0, 0, 4'h0, 0, 1, 0);
    add(1, 1, 0, 1, 1, 0, 4'hA, 1, 0, 0);
    add(1, 0, 0, 0, 0, 1, 4'hA, 0, 0, 0);
    // MSB first 1,0 | stall 3 cycles | 1,1 -> B.
    add(1, 1, 1, 0, 1, 0, 4'hA, 0, 1, 0);
    add(1, 1, 0, 0, 0, 0, 4'hA, 0, 1, 0);
    add(1, 0, 0, 0, 1, 0, 4'hA, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 4'hA, 0, 1, 0);
    add(1, 0, 0, 0, 1, 0, 4'hA, 0, 1, 0);
    add(1, 1, 0, 0, 1, 0, 4'hA, 0, 1, 0);
    add(1, 1, 0, 0, 1, 0, 4'hB, 1, 0, 0);
    add(1, 0, 0, 0, 0, 1, 4'hB, 0, 0, 0);
    // Frame 3 then back-to-back frame C without ACK -> overrun.
    add(1, 1, 1, 0, 0, 0, 4'hB, 0, 1, 0);
    add(1, 1, 0, 0, 0, 0, 4'hB, 0, 1, 0);
    add(1, 1, 0, 0, 1, 0, 4'hB, 0, 1, 0);
    add(1, 1, 0, 0, 1, 0, 4'h3, 1, 0, 0);
    add(1, 1, 1, 0, 1, 0, 4'h3, 1, 1, 0);
    add(1, 1, 0, 0, 1, 0, 4'h3, 1, 1, 0);
    add(1, 1, 0, 0, 0, 0, 4'h3, 1, 1, 0);
    add(1, 1, 0, 0, 0, 0, 4'h3, 1, 0, 1);
    // ACK clears VALID; ACK while idle changes nothing; OVERRUN sticky.
    add(1, 0, 0, 0, 0, 1, 4'h3, 0, 0, 1);
    add(1, 0, 0, 0, 0, 1, 4'h3, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0);
    // Same two frames, ACK on the second completion edge.
    add(1, 1, 1, 0, 0, 0, 4'h0, 0, 1, 0);
    add(1, 1, 0, 0, 0, 0, 4'h0, 0, 1, 0);
    add(1, 1, 0, 0, 1, 0, 4'h0, 0, 1, 0);
    add(1, 1, 0, 0, 1, 0, 4'h3, 1, 0, 0);
    add(1, 1, 1, 0, 1, 0, 4'h3, 1, 1, 0);
    add(1, 1, 0, 0, 1, 0, 4'h3, 1, 1, 0);
    add(1, 1, 0, 0, 0, 0, 4'h3, 1, 1, 0);
    add(1, 1, 0, 0, 0, 1, 4'hC, 1, 0, 0);
    // Restart after two bits, then 1,0,0,1 -> 9.
    add(1, 0, 0, 0, 0, 1, 4'hC, 0, 0, 0);
    add(1, 1, 1, 0, 1, 0, 4'hC, 0, 1, 0);
    add(1, 1, 0, 0, 1, 0, 4'hC, 0, 1, 0);
    add(1, 1, 1, 0, 1, 0, 4'hC, 0, 1, 0);
    add(1, 1, 0, 0, 0, 0, 4'hC, 0, 1, 0);
    add(1, 1, 0, 0, 0, 0, 4'hC, 0, 1, 0);
    add(1, 1, 0, 0, 1, 0, 4'h9, 1, 0, 0);
    add(1, 0, 0, 0, 0, 1, 4'h9, 0, 0, 0);
    // Reset after two bits, then frame 5.
    add(1, 1, 1, 0, 1, 0, 4'h9, 0, 1, 0);
    add(1, 1, 0, 0, 0, 0, 4'h9, 0, 1, 0);
    add(0, 1, 1, 0, 1, 0, 4'h0, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0, 4'h0, 0, 1, 0);
    add(1, 1, 0, 0, 1, 0, 4'h0, 0, 1, 0);
    add(1, 1, 0, 0, 0, 0, 4'h0, 0, 1, 0);
    add(1, 1, 0, 0, 1, 0, 4'h5, 1, 0, 0);
    // START without ENB is ignored.
    add(1, 0, 1, 0, 1, 1, 4'h5, 0, 0, 0);
    add(1, 0, 1, 0, 1, 0, 4'h5, 0, 0, 0);

    foreach (vq[k]) begin
      drive(vq[k].rst_n, vq[k].enb, vq[k].start, vq[k].dir, vq[k].s_in, vq[k].ack);
      check($sformatf("vec%0d", k), vq[k].q, vq[k].valid, vq[k].busy, vq[k].overrun);
    end

    // Loopback from a PUSH-mode shift register loaded with D, MSB out first.
    sr = 4'hD;
    for (int k = 0; k < WIDTH; k++) begin
      drive(1'b1, 1'b1, (k == 0), 1'b0, sr[WIDTH-1], 1'b0);
      sr = {sr[WIDTH-2:0], 1'b0};
      if (k == WIDTH - 2) check("loop_before_last", 4'h5, 1'b0, 1'b1, 1'b0);
    end
    check("loop_done", 4'hD, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("loop_ack", 4'hD, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("loop_hold", 4'hD, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
